// File: rtl/cfs_tx_ctrl_skid.sv
// Registered TX controller: a 2-entry skid buffer between the TX FIFO pop port and md_tx,
// with enable gating, zero-size drop, transfer/drop counters and a stall watchdog.
module cfs_tx_ctrl_skid #(
    parameter  int ALGN_DATA_WIDTH   = 32,
    parameter  int CNT_WIDTH         = 16,
    localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
    localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
    localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         cnt_clr,
    input  logic [CNT_WIDTH-1:0]         stall_threshold,
    input  logic                         pop_valid,
    input  logic [FIFO_DATA_WIDTH-1:0]   pop_data,
    output logic                         pop_ready,
    output logic                         md_tx_valid,
    output logic [ALGN_DATA_WIDTH-1:0]   md_tx_data,
    output logic [ALGN_OFFSET_WIDTH-1:0] md_tx_offset,
    output logic [ALGN_SIZE_WIDTH-1:0]   md_tx_size,
    input  logic                         md_tx_ready,
    output logic [CNT_WIDTH-1:0]         tx_cnt,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
    output logic [CNT_WIDTH-1:0]         stall_cnt,
    output logic                         stall_timeout
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t occ, occ_next;

    logic [ALGN_DATA_WIDTH-1:0]   pop_dat;
    logic [ALGN_OFFSET_WIDTH-1:0] pop_off;
    logic [ALGN_SIZE_WIDTH-1:0]   pop_size;

    logic [ALGN_DATA_WIDTH-1:0]   t_data;
    logic [ALGN_OFFSET_WIDTH-1:0] t_offset;
    logic [ALGN_SIZE_WIDTH-1:0]   t_size;

    logic acc, st, drop, snd;
    logic load_h_pop, load_h_t, load_t_pop;

    assign pop_dat  = pop_data[ALGN_DATA_WIDTH-1:0];
    assign pop_off  = pop_data[ALGN_DATA_WIDTH +: ALGN_OFFSET_WIDTH];
    assign pop_size = pop_data[ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH +: ALGN_SIZE_WIDTH];

    assign md_tx_valid = (occ != OCC_EMPTY);
    assign pop_ready   = !reset && enable && (occ != OCC_TWO);
    assign acc         = pop_valid && pop_ready;
    assign st          = acc && (pop_size != '0);
    assign drop        = acc && (pop_size == '0);
    assign snd         = md_tx_valid && md_tx_ready;

    assign stall_timeout = (stall_threshold != '0) && (stall_cnt >= stall_threshold);

    // A stored entry lands in the first slot left free after this cycle's retire.
    always_comb begin
        occ_next   = occ;
        load_h_pop = 1'b0;
        load_h_t   = 1'b0;
        load_t_pop = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (st) begin
                    occ_next   = OCC_ONE;
                    load_h_pop = 1'b1;
                end
            end
            OCC_ONE: begin
                if (snd && st) begin
                    load_h_pop = 1'b1;
                end else if (snd) begin
                    occ_next = OCC_EMPTY;
                end else if (st) begin
                    occ_next   = OCC_TWO;
                    load_t_pop = 1'b1;
                end
            end
            OCC_TWO: begin
                if (snd) begin
                    occ_next = OCC_ONE;
                    load_h_t = 1'b1;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ          <= OCC_EMPTY;
            md_tx_data   <= '0;
            md_tx_offset <= '0;
            md_tx_size   <= '0;
            t_data       <= '0;
            t_offset     <= '0;
            t_size       <= '0;
        end else begin
            occ <= occ_next;
            if (load_h_pop) begin
                md_tx_data   <= pop_dat;
                md_tx_offset <= pop_off;
                md_tx_size   <= pop_size;
            end else if (load_h_t) begin
                md_tx_data   <= t_data;
                md_tx_offset <= t_offset;
                md_tx_size   <= t_size;
            end
            if (load_t_pop) begin
                t_data   <= pop_dat;
                t_offset <= pop_off;
                t_size   <= pop_size;
            end
        end
    end

    // Counter clear wins over a same-cycle increment; the stall counter ignores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt    <= '0;
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (cnt_clr) begin
                tx_cnt <= '0;
            end else if (snd) begin
                tx_cnt <= tx_cnt + 1'b1;
            end

            if (cnt_clr) begin
                drop_cnt <= '0;
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            if (!md_tx_valid || snd) begin
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfs_tx_ctrl_skid.sv
// Self-checking bench for cfs_tx_ctrl_skid: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_cfs_tx_ctrl_skid;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [3:0]  stall_threshold = 4'd0;
    logic        pop_valid = 1'b0;
    logic [36:0] pop_data = '0;
    logic        pop_ready;
    logic        md_tx_valid;
    logic [31:0] md_tx_data;
    logic [1:0]  md_tx_offset;
    logic [2:0]  md_tx_size;
    logic        md_tx_ready = 1'b0;
    logic [3:0]  tx_cnt;
    logic [3:0]  drop_cnt;
    logic [3:0]  stall_cnt;
    logic        stall_timeout;

    cfs_tx_ctrl_skid #(
        .ALGN_DATA_WIDTH(32),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .cnt_clr(cnt_clr),
        .stall_threshold(stall_threshold),
        .pop_valid(pop_valid),
        .pop_data(pop_data),
        .pop_ready(pop_ready),
        .md_tx_valid(md_tx_valid),
        .md_tx_data(md_tx_data),
        .md_tx_offset(md_tx_offset),
        .md_tx_size(md_tx_size),
        .md_tx_ready(md_tx_ready),
        .tx_cnt(tx_cnt),
        .drop_cnt(drop_cnt),
        .stall_cnt(stall_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  o;
        logic [2:0]  s;
    } ent_t;

    typedef struct {
        logic        en;
        logic        pv;
        logic [31:0] d;
        logic [2:0]  sz;
        logic        rdy;
        logic        e_pr;
        logic        e_v;
        logic [31:0] e_d;
        logic [2:0]  e_sz;
        logic [3:0]  e_tx;
        logic [3:0]  e_drop;
    } vec_t;

    ent_t q[$];
    int   m_tx = 0;
    int   m_drop = 0;
    int   m_stall = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [3:0] thr_sel = 4'd0;
    vec_t vecs[13];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic clr, input logic pv,
                                 input logic [31:0] d, input logic [1:0] off, input logic [2:0] sz,
                                 input logic rdy);
        @(negedge clk);
        reset           = rst;
        enable          = en;
        cnt_clr         = clr;
        pop_valid       = pv;
        pop_data        = {sz, off, d};
        md_tx_ready     = rdy;
        stall_threshold = thr_sel;
    endtask

    task automatic checkOutput(input string tag);
        logic exp_pr;
        logic exp_to;
        #1;
        exp_pr = !reset && enable && (q.size() < 2);
        exp_to = (stall_threshold != 4'd0) && (m_stall >= int'(stall_threshold));
        cmp({tag, ".pop_ready"}, 32'(pop_ready), 32'(exp_pr));
        cmp({tag, ".md_tx_valid"}, 32'(md_tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            cmp({tag, ".md_tx_data"}, md_tx_data, q[0].d);
            cmp({tag, ".md_tx_offset"}, 32'(md_tx_offset), 32'(q[0].o));
            cmp({tag, ".md_tx_size"}, 32'(md_tx_size), 32'(q[0].s));
        end
        cmp({tag, ".tx_cnt"}, 32'(tx_cnt), 32'(m_tx));
        cmp({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        cmp({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        cmp({tag, ".stall_timeout"}, 32'(stall_timeout), 32'(exp_to));
    endtask

    // Reference model: a FIFO of up to two entries, updated at each clock edge.
    task automatic advance();
        logic valid, snd, acc;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_tx    = 0;
            m_drop  = 0;
            m_stall = 0;
        end else begin
            valid = (q.size() != 0);
            snd   = valid && md_tx_ready;
            acc   = pop_valid && enable && (q.size() < 2);
            m_stall = (!valid || snd) ? 0 : ((m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX);
            if (cnt_clr) m_tx = 0;
            else if (snd) m_tx = (m_tx + 1) % (CNT_MAX + 1);
            if (cnt_clr) m_drop = 0;
            else if (acc && pop_data[36:34] == 3'd0 && m_drop < CNT_MAX) m_drop = m_drop + 1;
            if (snd) void'(q.pop_front());
            if (acc && pop_data[36:34] != 3'd0) begin
                e.d = pop_data[31:0];
                e.o = pop_data[33:32];
                e.s = pop_data[36:34];
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic clr, input logic pv,
                        input logic [31:0] d, input logic [1:0] off, input logic [2:0] sz,
                        input logic rdy, input string tag);
        applyStimulus(rst, en, clr, pv, d, off, sz, rdy);
        checkOutput(tag);
        advance();
    endtask

    initial begin
        int rdy_pct;

        vecs[0]  = '{1'b1, 1'b1, 32'h11, 3'd4, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0, 4'd0, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h22, 3'd4, 1'b1, 1'b1, 1'b1, 32'h11, 3'd4, 4'd0, 4'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'h33, 3'd4, 1'b0, 1'b1, 1'b1, 32'h22, 3'd4, 4'd1, 4'd0};
        vecs[3]  = '{1'b1, 1'b1, 32'h44, 3'd4, 1'b0, 1'b0, 1'b1, 32'h22, 3'd4, 4'd1, 4'd0};
        vecs[4]  = '{1'b1, 1'b1, 32'h44, 3'd4, 1'b0, 1'b0, 1'b1, 32'h22, 3'd4, 4'd1, 4'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'h44, 3'd4, 1'b1, 1'b0, 1'b1, 32'h22, 3'd4, 4'd1, 4'd0};
        vecs[6]  = '{1'b1, 1'b1, 32'h44, 3'd4, 1'b1, 1'b1, 1'b1, 32'h33, 3'd4, 4'd2, 4'd0};
        vecs[7]  = '{1'b1, 1'b1, 32'h55, 3'd0, 1'b1, 1'b1, 1'b1, 32'h44, 3'd4, 4'd3, 4'd0};
        vecs[8]  = '{1'b1, 1'b1, 32'h66, 3'd2, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0, 4'd4, 4'd1};
        vecs[9]  = '{1'b1, 1'b0, 32'h77, 3'd4, 1'b0, 1'b1, 1'b1, 32'h66, 3'd2, 4'd4, 4'd1};
        vecs[10] = '{1'b0, 1'b1, 32'h77, 3'd4, 1'b0, 1'b0, 1'b1, 32'h66, 3'd2, 4'd4, 4'd1};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b1, 1'b0, 1'b1, 32'h66, 3'd2, 4'd4, 4'd1};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0, 4'd5, 4'd1};

        // Reset held three cycles with a pending pop, then release.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hAB, 2'd0, 3'd4, 1'b1);
        #1;
        cmp("rst0.pop_ready", 32'(pop_ready), 32'd0);
        advance();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hAB, 2'd0, 3'd4, 1'b1, "rst1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hAB, 2'd0, 3'd4, 1'b1);
        checkOutput("rst2");
        cmp("rst2.md_tx_data_zero", md_tx_data, 32'd0);
        cmp("rst2.md_tx_size_zero", 32'(md_tx_size), 32'd0);
        cmp("rst2.md_tx_offset_zero", 32'(md_tx_offset), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hA5, 2'd0, 3'd4, 1'b1);
        checkOutput("rel0");
        cmp("rel0.pop_ready", 32'(pop_ready), 32'd1);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("rel1");
        cmp("rel1.md_tx_data", md_tx_data, 32'hA5);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("clr_hs");
        cmp("clr_hs.tx_cnt", 32'(tx_cnt), 32'd0);
        advance();

        // Directed table: streaming, backpressure, drop and enable gating.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, vecs[i].en, 1'b0, vecs[i].pv, vecs[i].d, 2'd0, vecs[i].sz, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.t_pop_ready", i), 32'(pop_ready), 32'(vecs[i].e_pr));
            cmp($sformatf("vec%0d.t_valid", i), 32'(md_tx_valid), 32'(vecs[i].e_v));
            if (vecs[i].e_v) begin
                cmp($sformatf("vec%0d.t_data", i), md_tx_data, vecs[i].e_d);
                cmp($sformatf("vec%0d.t_size", i), 32'(md_tx_size), 32'(vecs[i].e_sz));
            end
            cmp($sformatf("vec%0d.t_tx_cnt", i), 32'(tx_cnt), 32'(vecs[i].e_tx));
            cmp($sformatf("vec%0d.t_drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
            advance();
        end

        // Eight back-to-back entries after a counter clear.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, "strm_clr");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'((i + 1) * 'h11), 2'd0, 3'd4, 1'b1);
            checkOutput($sformatf("strm%0d", i));
            if (i > 0) cmp($sformatf("strm%0d.data", i), md_tx_data, 32'(i * 'h11));
            advance();
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, "strm_last");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("strm_done");
        cmp("strm_done.tx_cnt", 32'(tx_cnt), 32'd8);
        advance();

        // Watchdog with threshold 3.
        thr_sel = 4'd3;
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBEEF, 2'd1, 3'd3, 1'b0, "wd_push");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0);
            checkOutput($sformatf("wd%0d", i));
            cmp($sformatf("wd%0d.timeout", i), 32'(stall_timeout), 32'(i == 3));
            advance();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("wd_hs");
        cmp("wd_hs.timeout", 32'(stall_timeout), 32'd1);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0);
        checkOutput("wd_after");
        cmp("wd_after.timeout", 32'(stall_timeout), 32'd0);
        cmp("wd_after.stall_cnt", 32'(stall_cnt), 32'd0);
        advance();

        // Threshold 0 never flags; stall counter saturates.
        thr_sel = 4'd0;
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE, 2'd2, 3'd1, 1'b0, "wd0_push");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0);
            checkOutput($sformatf("wd0_%0d", i));
            cmp($sformatf("wd0_%0d.timeout", i), 32'(stall_timeout), 32'd0);
            advance();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("wd0_sat");
        cmp("wd0_sat.stall_cnt", 32'(stall_cnt), 32'd15);
        advance();

        // Enable low with two buffered entries: drains, nothing new popped.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h101, 2'd0, 3'd4, 1'b0, "en_fill0");
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h202, 2'd0, 3'd4, 1'b0, "en_fill1");
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h303, 2'd0, 3'd4, 1'b1, "en_drain0");
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h303, 2'd0, 3'd4, 1'b1, "en_drain1");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h303, 2'd0, 3'd4, 1'b1);
        checkOutput("en_empty");
        cmp("en_empty.valid", 32'(md_tx_valid), 32'd0);
        advance();

        // Reset with two buffered entries discards them.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 2'd0, 3'd4, 1'b0, "mr_fill0");
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h505, 2'd0, 3'd4, 1'b0, "mr_fill1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h606, 2'd0, 3'd4, 1'b0);
        checkOutput("mr_rst");
        cmp("mr_rst.pop_ready", 32'(pop_ready), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1);
        checkOutput("mr_after");
        cmp("mr_after.valid", 32'(md_tx_valid), 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int blk = 0; blk < 6; blk++) begin
            thr_sel = 4'($urandom_range(0, 6));
            rdy_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                     $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
                     $urandom_range(0, 99) < rdy_pct, $sformatf("rnd%0d_%0d", blk, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
